// File: rtl/bus_cycle_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_decoder_pkg
// Description : Shared state, cycle-type and wait-count definitions for the
//               8088 local-bus cycle decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_cycle_decoder_pkg;

    localparam int unsigned c_CNT_W    = 3;
    localparam int unsigned c_MAX_WAIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_XFER = 2'd3
    } bcd_state_e;

    // Encoded as {io, write} so the value doubles as a strobe index.
    typedef enum logic [1:0] {
        CYC_MEM_RD = 2'd0,
        CYC_MEM_WR = 2'd1,
        CYC_IO_RD  = 2'd2,
        CYC_IO_WR  = 2'd3
    } bcd_cycle_e;

    function automatic bcd_cycle_e cycle_type(input logic io, input logic rd);
        return bcd_cycle_e'({io, ~rd});
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cycle_decoder_wait.sv
`default_nettype none
// ============================================================================
// Module      : wait_state_counter
// Description : Loadable down-counter that saturates at zero; sets the
//               wait-state length of a bus cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_state_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/bus_cycle_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_decoder
// Description : Demultiplexes the 8088 AD bus, decodes memory/I/O strobes,
//               inserts wait states and returns read data onto the AD bus.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_decoder
    import bus_cycle_decoder_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ale,
    input  logic [11:0] a,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        iom,
    output logic        ready,
    output logic [19:0] dev_addr,
    output logic [7:0]  dev_wdata,
    input  logic [7:0]  dev_rdata,
    input  logic        dev_wait,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        io_rd,
    output logic        io_wr,
    output logic        bus_err
);

    if (MEM_WAIT > c_MAX_WAIT) begin : g_bad_mem_wait
        $error("bus_cycle_decoder: MEM_WAIT must be in 0..7");
    end
    if (IO_WAIT > c_MAX_WAIT) begin : g_bad_io_wait
        $error("bus_cycle_decoder: IO_WAIT must be in 0..7");
    end

    localparam logic [c_CNT_W-1:0] c_MEM_LOAD = c_CNT_W'(MEM_WAIT);
    localparam logic [c_CNT_W-1:0] c_IO_LOAD  = c_CNT_W'(IO_WAIT);

    bcd_state_e   state_q, state_d;
    bcd_cycle_e   cyc_d;
    logic [19:0]  addr_q, addr_d;
    logic [7:0]   wdata_q, wdata_d;
    logic [7:0]   ad_out_q, ad_out_d;
    logic         ad_oe_q, ad_oe_d;
    logic         io_q, io_d;
    logic         read_q, read_d;
    logic         err_q, err_d;
    logic         abort_q, abort_d;
    logic         bus_err_q, bus_err_d;
    logic         ready_q, ready_d;
    logic [3:0]   strobe_q, strobe_d;

    logic               cnt_load;
    logic               cnt_dec;
    logic               cnt_zero;
    logic [c_CNT_W-1:0] cnt_load_val;

    assign cnt_load_val = io_q ? c_IO_LOAD : c_MEM_LOAD;

    wait_state_counter #(
        .WIDTH (c_CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ad_out_d  = ad_out_q;
        io_d      = io_q;
        read_d    = read_q;
        err_d     = err_q;
        abort_d   = abort_q;
        bus_err_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ale) begin
                    addr_d  = {a, ad_in};
                    io_d    = iom;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ale) begin
                    addr_d = {a, ad_in};
                    io_d   = iom;
                end else if (!rd_n && wr_n) begin
                    read_d   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_WAIT;
                end else if (!wr_n && rd_n) begin
                    read_d   = 1'b0;
                    wdata_d  = ad_in;
                    cnt_load = 1'b1;
                    state_d  = ST_WAIT;
                end else if (!rd_n && !wr_n) begin
                    read_d    = 1'b0;
                    err_d     = 1'b1;
                    bus_err_d = 1'b1;
                    state_d   = ST_XFER;
                end
            end
            ST_WAIT: begin
                cnt_dec = !cnt_zero;
                // CPU released its strobe early: flag once, but keep counting down.
                if (rd_n && wr_n && !abort_q) begin
                    abort_d   = 1'b1;
                    bus_err_d = 1'b1;
                end
                if (cnt_zero && !dev_wait) begin
                    if (abort_d) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (read_q) begin
                            ad_out_d = dev_rdata;
                        end
                        state_d = ST_XFER;
                    end
                end
            end
            ST_XFER: begin
                if (rd_n && wr_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they register in step with it.
        cyc_d    = cycle_type(io_d, read_d);
        strobe_d = '0;
        if (state_d == ST_WAIT) begin
            strobe_d[cyc_d] = 1'b1;
        end
        ready_d = (state_d != ST_WAIT);
        ad_oe_d = (state_d == ST_XFER) && read_d && !err_d && !rd_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            ad_out_q  <= '0;
            ad_oe_q   <= 1'b0;
            io_q      <= 1'b0;
            read_q    <= 1'b0;
            err_q     <= 1'b0;
            abort_q   <= 1'b0;
            bus_err_q <= 1'b0;
            ready_q   <= 1'b1;
            strobe_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ad_out_q  <= ad_out_d;
            ad_oe_q   <= ad_oe_d;
            io_q      <= io_d;
            read_q    <= read_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
            bus_err_q <= bus_err_d;
            ready_q   <= ready_d;
            strobe_q  <= strobe_d;
        end
    end

    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign ad_out    = ad_out_q;
    assign ad_oe     = ad_oe_q;
    assign ready     = ready_q;
    assign bus_err   = bus_err_q;
    assign mem_rd    = strobe_q[CYC_MEM_RD];
    assign mem_wr    = strobe_q[CYC_MEM_WR];
    assign io_rd     = strobe_q[CYC_IO_RD];
    assign io_wr     = strobe_q[CYC_IO_WR];

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_cycle_decoder
// Description : Directed self-checking bench for bus_cycle_decoder with a
//               scoreboard of expected bus cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_decoder;

    localparam logic [3:0] S_MEM_RD = 4'b0001;
    localparam logic [3:0] S_MEM_WR = 4'b0010;
    localparam logic [3:0] S_IO_RD  = 4'b0100;
    localparam logic [3:0] S_IO_WR  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ale = 1'b0;
    logic [11:0] a = '0;
    logic [7:0]  ad_in = '0;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic        iom = 1'b0;
    logic [7:0]  dev_rdata = '0;
    logic        dev_wait = 1'b0;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic        ready;
    logic [19:0] dev_addr;
    logic [7:0]  dev_wdata;
    logic        mem_rd, mem_wr, io_rd, io_wr;
    logic        bus_err;
    logic [3:0]  strb;

    assign strb = {io_wr, io_rd, mem_wr, mem_rd};

    bus_cycle_decoder #(
        .MEM_WAIT (1),
        .IO_WAIT  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ale       (ale),
        .a         (a),
        .ad_in     (ad_in),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .iom       (iom),
        .ready     (ready),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rdata (dev_rdata),
        .dev_wait  (dev_wait),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  strb;
        int          len;
        logic [19:0] addr;
        logic        chk_w;
        logic [7:0]  wdata;
        logic        chk_r;
        logic [7:0]  rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   mon_done  = 0;
    int   exp_done  = 0;
    int   mon_len   = 0;
    logic [3:0] s_and = '0;
    logic [3:0] s_or  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cycle(input logic [3:0] s, input int len, input logic [19:0] ad,
                                input logic cw, input logic [7:0] wd,
                                input logic cr, input logic [7:0] rd);
        exp_t e;
        e.strb = s; e.len = len; e.addr = ad;
        e.chk_w = cw; e.wdata = wd; e.chk_r = cr; e.rdata = rd;
        exp_q.push_back(e);
        exp_done++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (mon_done >= exp_done) break;
            @(negedge clk);
            #1;
        end
        check("cycle_complete", 32'(mon_done >= exp_done), 1);
    endtask

    // Scoreboard monitor: one record per ready-low window.
    always @(negedge clk) begin
        if (rst) begin
            mon_len = 0;
        end else begin
            check("strobe_onehot0", 32'($onehot0(strb)), 1);
            if (!ready) begin
                if (mon_len == 0) begin
                    s_and = strb;
                    s_or  = strb;
                end else begin
                    s_and = s_and & strb;
                    s_or  = s_or | strb;
                end
                mon_len++;
            end else if (mon_len != 0) begin
                check("expect_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("strobe_held", {28'd0, s_and}, {28'd0, e.strb});
                    check("strobe_only", {28'd0, s_or}, {28'd0, e.strb});
                    check("ready_low_cycles", mon_len, e.len);
                    check("dev_addr", {12'd0, dev_addr}, {12'd0, e.addr});
                    if (e.chk_w) check("dev_wdata", {24'd0, dev_wdata}, {24'd0, e.wdata});
                    if (e.chk_r) check("ad_out", {24'd0, ad_out}, {24'd0, e.rdata});
                end
                mon_len = 0;
                mon_done++;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_strobes", strb, 0);
        check("rst_dev_addr", dev_addr, 0);
        check("rst_dev_wdata", dev_wdata, 0);
        check("rst_ad_out", ad_out, 0);
        check("rst_ad_oe", ad_oe, 0);
        check("rst_bus_err", bus_err, 0);
        rst = 1'b0;

        // Memory read
        tick(); ale = 1'b1; a = 12'hABC; ad_in = 8'h12; iom = 1'b0;
        tick(); ale = 1'b0; rd_n = 1'b0; ad_in = 8'h00; dev_rdata = 8'h5A;
        expect_cycle(S_MEM_RD, 2, 20'hABC12, 1'b0, 8'h00, 1'b1, 8'h5A);
        wait_done();
        check("rd_ad_oe_xfer", ad_oe, 1);
        check("rd_ad_out_xfer", ad_out, 8'h5A);
        check("rd_strobe_drop", strb, 0);
        tick(); rd_n = 1'b1;
        tick();
        check("rd_ad_oe_idle", ad_oe, 0);

        // I/O write
        tick(); ale = 1'b1; a = 12'h003; ad_in = 8'hF8; iom = 1'b1;
        tick(); ale = 1'b0; wr_n = 1'b0; ad_in = 8'hC3;
        expect_cycle(S_IO_WR, 4, 20'h003F8, 1'b1, 8'hC3, 1'b0, 8'h00);
        wait_done();
        check("wr_ad_oe", ad_oe, 0);
        tick(); wr_n = 1'b1;
        tick();

        // Device stretch
        tick(); ale = 1'b1; a = 12'h400; ad_in = 8'h10; iom = 1'b0;
        tick(); ale = 1'b0; rd_n = 1'b0; dev_wait = 1'b1; dev_rdata = 8'hA5;
        expect_cycle(S_MEM_RD, 5, 20'h40010, 1'b0, 8'h00, 1'b1, 8'hA5);
        repeat (5) tick();
        dev_wait = 1'b0;
        wait_done();
        tick(); rd_n = 1'b1;
        tick();

        // Protocol error
        tick(); ale = 1'b1; a = 12'h007; ad_in = 8'h77; iom = 1'b0;
        tick(); ale = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        tick();
        check("err_pulse", bus_err, 1);
        check("err_no_strobe", strb, 0);
        check("err_ready", ready, 1);
        tick();
        check("err_pulse_end", bus_err, 0);
        check("err_ad_oe", ad_oe, 0);
        rd_n = 1'b1; wr_n = 1'b1;
        tick();

        // Re-latch in ADDR, ignore ale during WAIT
        tick(); ale = 1'b1; a = 12'hAAA; ad_in = 8'h55; iom = 1'b0;
        tick(); a = 12'h123; ad_in = 8'h45;
        tick(); ale = 1'b0; rd_n = 1'b0; dev_rdata = 8'h3C;
        expect_cycle(S_MEM_RD, 2, 20'h12345, 1'b0, 8'h00, 1'b1, 8'h3C);
        tick(); ale = 1'b1; a = 12'hFFF; ad_in = 8'hFF;
        tick(); ale = 1'b0;
        wait_done();
        check("relatch_addr", dev_addr, 20'h12345);
        tick(); rd_n = 1'b1;
        tick();

        // Early strobe release during WAIT
        tick(); ale = 1'b1; a = 12'h000; ad_in = 8'h60; iom = 1'b1;
        tick(); ale = 1'b0; rd_n = 1'b0; dev_rdata = 8'hEE;
        expect_cycle(S_IO_RD, 4, 20'h00060, 1'b0, 8'h00, 1'b0, 8'h00);
        tick(); rd_n = 1'b1;
        tick();
        check("abort_err_pulse", bus_err, 1);
        tick();
        check("abort_err_end", bus_err, 0);
        wait_done();
        check("abort_ad_oe", ad_oe, 0);
        check("abort_ad_out", ad_out, 8'h3C);
        tick();

        // Reset mid-WAIT
        tick(); ale = 1'b1; a = 12'h000; ad_in = 8'h80; iom = 1'b1;
        tick(); ale = 1'b0; rd_n = 1'b0;
        tick();
        check("pre_rst_io_rd", io_rd, 1);
        check("pre_rst_ready", ready, 0);
        tick(); rst = 1'b1;
        #1;
        check("async_rst_io_rd", io_rd, 0);
        check("async_rst_ready", ready, 1);
        check("async_rst_ad_oe", ad_oe, 0);
        check("async_rst_addr", dev_addr, 0);
        tick(); rst = 1'b0; rd_n = 1'b1;

        // Clean cycle after reset
        tick(); ale = 1'b1; a = 12'h0BE; ad_in = 8'hEF; iom = 1'b0;
        tick(); ale = 1'b0; rd_n = 1'b0; dev_rdata = 8'h77;
        expect_cycle(S_MEM_RD, 2, 20'h0BEEF, 1'b0, 8'h00, 1'b1, 8'h77);
        wait_done();
        check("post_rst_ad_oe", ad_oe, 1);
        tick(); rd_n = 1'b1;
        tick();
        check("post_rst_idle_oe", ad_oe, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_cycle_decoder.md
Name: bus_cycle_decoder

Overview:
- Downstream of the 8088 processor wrapper on the CPU local bus.
- Demultiplexes the multiplexed AD bus using ALE and captures a full 20-bit address.
- Decodes rd_n/wr_n/iom into memory or I/O read/write strobes for on-board devices.
- Inserts programmable wait states by deasserting ready, and returns read data onto the AD bus.

Parameters:
- MEM_WAIT, 1, extra wait cycles for memory cycles (0-7)
- IO_WAIT, 3, extra wait cycles for I/O cycles (0-7)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ale  in  1  address latch enable from CPU
- a  in  12  CPU address bits [19:8]
- ad_in  in  8  AD bus as sampled (address or write data)
- ad_out  out  8  read data to drive onto AD bus
- ad_oe  out  1  AD bus drive enable (top level builds the tri-state)
- rd_n  in  1  CPU read strobe, active low
- wr_n  in  1  CPU write strobe, active low
- iom  in  1  1=I/O, 0=memory
- ready  out  1  to CPU; 0 inserts a wait state
- dev_addr  out  20  latched address
- dev_wdata  out  8  latched write data
- dev_rdata  in  8  device read data
- dev_wait  in  1  device requests extra wait cycles
- mem_rd, mem_wr, io_rd, io_wr  out  1 each  device strobes, active high
- bus_err  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (rst=1, asynchronous):
  - State IDLE.
  - dev_addr=0, dev_wdata=0, ad_out=0, ad_oe=0.
  - All strobes 0, ready=1, bus_err=0, wait counter 0.
- All state is registered on the rising edge of clk. All outputs are registered.
- States: IDLE, ADDR, WAIT, XFER.
- IDLE:
  - When ale=1: dev_addr<={a,ad_in}, cycle type<=iom, then go to ADDR.
- ADDR:
  - ale=1 again: re-latch the address and stay in ADDR.
  - rd_n=0 and wr_n=1: read cycle. Go to WAIT and load the counter with MEM_WAIT or IO_WAIT per latched iom.
  - wr_n=0 and rd_n=1: write cycle. dev_wdata<=ad_in, go to WAIT, load the counter the same way.
  - rd_n=0 and wr_n=0: bus_err pulses for 1 cycle, no strobe is issued, go to XFER with the error flag set.
- WAIT:
  - Exactly one device strobe is high, chosen by type and direction (mem_rd/mem_wr/io_rd/io_wr).
  - ready=0.
  - Counter decrements each cycle while nonzero.
  - Exit when counter==0 and dev_wait=0. WAIT therefore lasts N+1 cycles plus one cycle per dev_wait-high cycle.
  - On exit of a read cycle: ad_out<=dev_rdata (sampled in the last WAIT cycle). Then go to XFER.
  - Strobe drops on entry to XFER.
- XFER:
  - ready=1.
  - For a read (no error): ad_oe=1 while rd_n=0.
  - Stay until rd_n=1 and wr_n=1, then go to IDLE with ad_oe=0.
- ale=1 in WAIT or XFER is ignored; the bus cycle is not aborted.
- Strobe deasserted before the transfer completes (rd_n and wr_n both high) in WAIT:
  - Finish the countdown anyway, then go to IDLE.
  - No ad_oe.
  - bus_err pulses 1 cycle.
- Reset mid-cycle: all outputs return to reset values immediately and asynchronously.
- Counter width is 3 bits; parameter values >7 are illegal (elaboration check).
- ready is never low outside WAIT.
- At most one device strobe is high in any cycle.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE/ADDR/WAIT/XFER);
  - the cycle-type constants (MEM/IO × RD/WR);
  - the maximum wait count.
- One natural sub-module: wait_state_counter, a 3-bit loadable down-counter with load, dec and zero outputs.
- Address/data latches stay inline.

Test Plan:
- Memory read, MEM_WAIT=1:
  - Stimulus: ale with a=12'hABC, ad_in=8'h12, iom=0; then rd_n=0; dev_rdata=8'h5A.
  - Response: dev_addr=20'hABC12; mem_rd high 2 cycles; ready low 2 cycles; ad_out=8'h5A with ad_oe=1 until rd_n rises.
- I/O write, IO_WAIT=3:
  - Stimulus: iom=1, address 20'h003F8, ad_in=8'hC3 when wr_n falls.
  - Response: io_wr high 4 cycles, dev_wdata=8'hC3, ready low 4 cycles, ad_oe stays 0.
- Device stretch:
  - Stimulus: memory read with dev_wait held high 3 extra cycles.
  - Response: ready low for MEM_WAIT+1+3 cycles; mem_rd held throughout.
- Protocol error:
  - Stimulus: rd_n=0 and wr_n=0 together in ADDR.
  - Response: bus_err single-cycle pulse, no strobe; return to IDLE after both strobes go high.
- Re-latch and ignore:
  - Stimulus: two ale pulses in ADDR (second address 20'h12345); then an ale pulse during WAIT.
  - Response: dev_addr=20'h12345 is kept and the WAIT-time pulse is ignored.
- Reset mid-WAIT:
  - Stimulus: assert rst during an I/O read.
  - Response: io_rd=0, ready=1, ad_oe=0 immediately; the next ale starts a clean cycle.
